// File: rtl/cntr8_state_dp.sv
// cntr8_state_dp: registered state and count stage of the up/down counter, with wrap pulses and a sticky illegal-state error.
module cntr8_state_dp #(
  parameter int WIDTH = 8,
  parameter logic [2:0] IDLE_STATE = 3'b000,
  parameter logic [2:0] LOAD_STATE = 3'b001,
  parameter logic [2:0] INC_STATE  = 3'b010,
  parameter logic [2:0] INC2_STATE = 3'b011,
  parameter logic [2:0] DEC_STATE  = 3'b100,
  parameter logic [2:0] DEC2_STATE = 3'b101
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       next_state,
  input  logic [WIDTH-1:0] d_in,
  output logic [2:0]       state,
  output logic [WIDTH-1:0] d_out,
  output logic             o_carry,
  output logic             o_borrow,
  output logic             o_err
);
  logic [2:0]       r_state, w_state;
  logic [WIDTH-1:0] r_d, w_d;
  logic             r_carry, r_borrow, r_err, w_carry, w_borrow, w_err;
  logic             w_inc, w_dec, w_legal;
  assign w_inc = (next_state == INC_STATE) | (next_state == INC2_STATE);
  assign w_dec = (next_state == DEC_STATE) | (next_state == DEC2_STATE);
  // an X/Z bit leaves w_legal unknown, so the if below falls to the illegal branch
  assign w_legal = w_inc | w_dec | (next_state == IDLE_STATE) | (next_state == LOAD_STATE);
  always_comb begin
    w_state = r_state;
    w_d = r_d;
    w_carry = 1'b0;
    w_borrow = 1'b0;
    w_err = r_err;
    if (en) begin
      if (w_legal) begin
        w_state = next_state;
        w_d = (next_state == IDLE_STATE) ? '0 :
              (next_state == LOAD_STATE) ? d_in :
              w_inc ? r_d + 1'b1 : r_d - 1'b1;
        w_carry = w_inc && (r_d == '1);
        w_borrow = w_dec && (r_d == '0);
      end else begin
        w_state = IDLE_STATE;
        w_d = '0;
        w_err = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE_STATE;
      r_d <= '0;
      r_carry <= 1'b0;
      r_borrow <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_state;
      r_d <= w_d;
      r_carry <= w_carry;
      r_borrow <= w_borrow;
      r_err <= w_err;
    end
  end
  assign state = r_state;
  assign d_out = r_d;
  assign o_carry = r_carry;
  assign o_borrow = r_borrow;
  assign o_err = r_err;
endmodule

// File: tb/tb_cntr8_state_dp.sv
// tb_cntr8_state_dp: directed scenarios plus random traffic against an arithmetic reference of the counter stage.
module tb_cntr8_state_dp;
  logic       clk = 1'b0;
  logic       reset, en;
  logic [2:0] next_state;
  logic [7:0] d_in;
  logic [2:0] state;
  logic [7:0] d_out;
  logic       o_carry, o_borrow, o_err;
  int total = 0, passed = 0;
  int m_state = 0, m_cnt = 0, m_cy = 0, m_bw = 0, m_err = 0;

  cntr8_state_dp dut (
    .clk(clk), .reset(reset), .en(en), .next_state(next_state), .d_in(d_in),
    .state(state), .d_out(d_out), .o_carry(o_carry), .o_borrow(o_borrow), .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
  endtask

  // reference: count kept as a plain integer modulo 256
  task automatic model(input int r, input int e, input int ns, input int d);
    if (r != 0) begin
      m_state = 0; m_cnt = 0; m_cy = 0; m_bw = 0; m_err = 0;
    end else if (e == 0) begin
      m_cy = 0; m_bw = 0;
    end else if (ns > 5) begin
      m_state = 0; m_cnt = 0; m_cy = 0; m_bw = 0; m_err = 1;
    end else begin
      m_cy = (ns == 2 || ns == 3) && m_cnt == 255;
      m_bw = (ns == 4 || ns == 5) && m_cnt == 0;
      m_state = ns;
      m_cnt = ns == 0 ? 0 : ns == 1 ? d : ns < 4 ? (m_cnt + 1) % 256 : (m_cnt + 255) % 256;
    end
  endtask

  task automatic step(input int r, input int e, input int ns, input int d, input string tag);
    reset = 1'(r); en = 1'(e); next_state = 3'(ns); d_in = 8'(d);
    @(posedge clk);
    model(r, e, ns, d);
    #1;
    chk({tag, ".state"}, int'(state), m_state);
    chk({tag, ".d_out"}, int'(d_out), m_cnt);
    chk({tag, ".carry"}, int'(o_carry), m_cy);
    chk({tag, ".borrow"}, int'(o_borrow), m_bw);
    chk({tag, ".err"}, int'(o_err), m_err);
  endtask

  initial begin
    step(1, 1, 1, 8'hA5, "rst0");
    step(1, 1, 1, 8'hA5, "rst1");
    chk("rst_dout_const", int'(d_out), 0);
    step(0, 1, 1, 8'hFD, "ld_fd");
    step(0, 1, 2, 0, "inc_fe");
    step(0, 1, 3, 0, "inc_ff");
    step(0, 1, 2, 0, "inc_00");
    chk("carry_at_00", int'({o_carry, d_out}), 9'h100);
    step(0, 1, 3, 0, "inc_01");
    chk("carry_drop", int'({o_carry, d_out}), 9'h001);
    step(0, 1, 1, 8'h02, "ld_02");
    step(0, 1, 4, 0, "dec_01");
    step(0, 1, 5, 0, "dec_00");
    step(0, 1, 4, 0, "dec_ff");
    chk("borrow_at_ff", int'({o_borrow, d_out}), 9'h1FF);
    step(0, 1, 5, 0, "dec_fe");
    step(0, 1, 1, 8'h40, "ld_40");
    for (int i = 0; i < 3; i++) step(0, 0, 2, 8'h11, "hold");
    chk("hold_40", int'(d_out), 8'h40);
    step(0, 1, 2, 0, "inc_41");
    chk("after_hold_41", int'(d_out), 8'h41);
    step(0, 1, 1, 8'h33, "ld_33");
    step(0, 1, 6, 8'h77, "illegal");
    chk("err_set", int'({o_err, state, d_out}), 12'h800);
    step(0, 1, 2, 0, "err_inc");
    step(0, 0, 7, 0, "illegal_hold");
    step(1, 1, 2, 0, "err_rst");
    chk("err_clear", int'(o_err), 0);
    step(0, 1, 1, 8'h7F, "ld_7f");
    step(0, 1, 2, 0, "inc_80");
    step(1, 1, 2, 0, "mid_rst");
    step(0, 1, 2, 0, "post_rst_inc");
    chk("post_rst_01", int'(d_out), 1);
    step(0, 1, 1, 8'hFF, "ld_ff");
    step(0, 1, 1, 8'h00, "ld_no_flag");
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 39) == 0) ? 1 : 0, ($urandom_range(0, 4) != 0) ? 1 : 0,
           ($urandom_range(0, 9) == 0) ? $urandom_range(6, 7) : $urandom_range(0, 5),
           $urandom_range(0, 255), "rand");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
